spi_ram_master: RTL and testbench

- Initiator end of the 10-bit SPI RAM command link. Accepts one RAM command at a time from a local host and serialises it MSB-first on MOSI, framed by SS_n.
- For read-data commands, waits a fixed turnaround, then deserialises the 8-bit RAM response from MISO.
- SPI shift timing is the shared system clock `clk`; no separate SCK is generated.

---
 rtl/spi_ram_master_if.sv | 24 ++
 rtl/spi_ram_master.sv | 111 +++++++++++
 tb/tb_spi_ram_master.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_master_if.sv
// Host command port and SPI pins of the 10-bit SPI RAM command link.
// The master modport is the initiator's view; slave is the host/RAM side.
interface spi_ram_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, MISO,
        output cmd_ready, SS_n, MOSI, rd_data, rd_valid, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, MISO,
        input  cmd_ready, SS_n, MOSI, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/spi_ram_master.sv
// SPI RAM command master: serialises {op, data} MSB-first under SS_n and,
// for read-data commands, captures an 8-bit reply after a fixed turnaround.
module spi_ram_master #(
    parameter int TURNAROUND = 2,
    parameter int GAP        = 1
) (
    input  logic             clk,
    input  logic             rst,
    spi_ram_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, SHIFT, WAIT, RECV, STOP} state_t;

    // Counters are loaded with "cycles - 1" and run down to zero.
    localparam logic [3:0] TA_LAST  = 4'(TURNAROUND - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    state_t     state;
    logic [9:0] frame;
    logic [3:0] bit_cnt;
    logic [3:0] ta_cnt;
    logic [3:0] gap_cnt;
    logic [6:0] shift;
    logic       ss_n_q;
    logic       mosi_q;
    logic [7:0] rd_data_q;
    logic       rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            frame      <= '0;
            bit_cnt    <= '0;
            ta_cnt     <= '0;
            gap_cnt    <= '0;
            shift      <= '0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        frame  <= {bus.cmd_op, bus.cmd_data};
                        ss_n_q <= 1'b0;
                        mosi_q <= 1'b0;
                        state  <= START;
                    end
                end
                START: begin
                    mosi_q  <= frame[9];
                    bit_cnt <= 4'd9;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt != 4'd0) begin
                        mosi_q  <= frame[bit_cnt - 4'd1];
                        bit_cnt <= bit_cnt - 4'd1;
                    end else begin
                        mosi_q <= 1'b0;
                        if (frame[9:8] != 2'b11) begin
                            ss_n_q  <= 1'b1;
                            gap_cnt <= GAP_LAST;
                            state   <= STOP;
                        end else if (TURNAROUND == 0) begin
                            bit_cnt <= 4'd7;
                            state   <= RECV;
                        end else begin
                            ta_cnt <= TA_LAST;
                            state  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (ta_cnt == 4'd0) begin
                        bit_cnt <= 4'd7;
                        state   <= RECV;
                    end else begin
                        ta_cnt <= ta_cnt - 4'd1;
                    end
                end
                RECV: begin
                    // The eighth sample bypasses the shifter straight into rd_data.
                    shift <= {shift[5:0], bus.MISO};
                    if (bit_cnt == 4'd0) begin
                        rd_data_q  <= {shift, bus.MISO};
                        rd_valid_q <= 1'b1;
                        ss_n_q     <= 1'b1;
                        gap_cnt    <= GAP_LAST;
                        state      <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                STOP: begin
                    if (gap_cnt == 4'd0) state <= IDLE;
                    else                 gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.SS_n      = ss_n_q;
    assign bus.MOSI      = mosi_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: two instances (TURNAROUND=2/GAP=1 and
// TURNAROUND=0/GAP=3) driven by randomized frames against a frame-level model.
module tb_spi_ram_master;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_ram_master_if if_a ();
    spi_ram_master_if if_b ();

    spi_ram_master #(.TURNAROUND(2), .GAP(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.master));
    spi_ram_master #(.TURNAROUND(0), .GAP(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b.master));

    logic       sel;
    logic       cv;
    logic       miso;
    logic [1:0] op;
    logic [7:0] dat;

    assign if_a.cmd_valid = cv & ~sel;
    assign if_b.cmd_valid = cv & sel;
    assign if_a.cmd_op    = op;
    assign if_b.cmd_op    = op;
    assign if_a.cmd_data  = dat;
    assign if_b.cmd_data  = dat;
    assign if_a.MISO      = miso;
    assign if_b.MISO      = miso;

    logic       ss_n, mosi, rv, rdy, bsy;
    logic [7:0] rdd;
    assign ss_n = sel ? if_b.SS_n     : if_a.SS_n;
    assign mosi = sel ? if_b.MOSI     : if_a.MOSI;
    assign rv   = sel ? if_b.rd_valid : if_a.rd_valid;
    assign rdy  = sel ? if_b.cmd_ready : if_a.cmd_ready;
    assign bsy  = sel ? if_b.busy     : if_a.busy;
    assign rdd  = sel ? if_b.rd_data  : if_a.rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] last_rd [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d) at %0t: got 0x%0h, expected 0x%0h", tag, sel, $time, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("idle_ss_n", 32'(ss_n), 32'd1);
            check_eq("idle_ready", 32'(rdy), 32'd1);
            check_eq("idle_rd_valid", 32'(rv), 32'd0);
        end
    endtask

    // One complete frame, checked cycle by cycle from the accept edge E0.
    // Sample c is taken on the falling edge after rising edge E_c.
    task automatic run_frame(input bit hold, input logic [1:0] o, input logic [7:0] d,
                             input logic [7:0] resp, input bit inject, input int abort_at);
        logic [9:0] f;
        logic       e_ss, e_mosi, e_rv, e_rdy;
        int         ta, gap, low_len, len, k;
        bit         rd;
        f       = {o, d};
        ta      = sel ? 0 : 2;
        gap     = sel ? 3 : 1;
        rd      = (o == 2'b11);
        low_len = rd ? 19 + ta : 11;
        len     = low_len + gap;
        check_eq("ready_pre", 32'(rdy), 32'd1);
        cv   = 1'b1;
        op   = o;
        dat  = d;
        miso = 1'($urandom);
        @(posedge clk);
        for (int c = 0; c <= len; c++) begin
            @(negedge clk);
            if (c == 0) begin
                op  = 2'($urandom);
                dat = 8'($urandom);
                if (!hold) cv = 1'b0;
            end
            if (inject && c == 4) begin
                cv  = 1'b1;
                op  = 2'b01;
                dat = 8'hFF;
            end
            if (inject && c == 5) cv = 1'b0;
            if (rd && c == low_len) last_rd[sel] = resp;
            e_ss   = (c >= low_len);
            e_mosi = 1'b0;
            if (c >= 1 && c <= 10) e_mosi = f[10 - c];
            e_rv   = rd && (c == low_len);
            e_rdy  = (c == len);
            check_eq("ss_n", 32'(ss_n), 32'(e_ss));
            check_eq("mosi", 32'(mosi), 32'(e_mosi));
            check_eq("rd_valid", 32'(rv), 32'(e_rv));
            check_eq("rd_data", 32'(rdd), 32'(last_rd[sel]));
            check_eq("cmd_ready", 32'(rdy), 32'(e_rdy));
            check_eq("busy", 32'(bsy), 32'(!e_rdy));
            k = c + 1 - (12 + ta);
            if (rd && k >= 0 && k <= 7) miso = resp[7 - k];
            else                        miso = 1'($urandom);
            if (c == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check_eq("rst_ss_n", 32'(ss_n), 32'd1);
                check_eq("rst_mosi", 32'(mosi), 32'd0);
                check_eq("rst_rd_valid", 32'(rv), 32'd0);
                check_eq("rst_rd_data", 32'(rdd), 32'd0);
                last_rd[0] = 8'h00;
                last_rd[1] = 8'h00;
                cv = 1'b0;
                @(negedge clk);
                check_eq("rst_hold_rd_valid", 32'(rv), 32'd0);
                check_eq("rst_ready", 32'(rdy), 32'd1);
                rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        cv   = 1'b0;
        sel  = 1'b0;
        op   = 2'b00;
        dat  = 8'h00;
        miso = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check_eq("reset_ss_n", 32'(ss_n), 32'd1);
            check_eq("reset_mosi", 32'(mosi), 32'd0);
            check_eq("reset_rd_valid", 32'(rv), 32'd0);
            check_eq("reset_rd_data", 32'(rdd), 32'd0);
            check_eq("reset_ready", 32'(rdy), 32'd1);
            check_eq("reset_busy", 32'(bsy), 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        run_frame(1'b0, 2'b00, 8'h5A, 8'h00, 1'b0, -1);
        run_frame(1'b0, 2'b11, 8'h00, 8'hC3, 1'b0, -1);

        // cmd_valid held high across four consecutive commands
        run_frame(1'b1, 2'b00, 8'($urandom), 8'h00, 1'b0, -1);
        run_frame(1'b1, 2'b01, 8'($urandom), 8'h00, 1'b0, -1);
        run_frame(1'b1, 2'b10, 8'($urandom), 8'h00, 1'b0, -1);
        run_frame(1'b0, 2'b11, 8'($urandom), 8'($urandom), 1'b0, -1);

        run_frame(1'b0, 2'b10, 8'($urandom), 8'h00, 1'b1, -1);
        idle_cycles(6);

        for (int i = 0; i < 10; i++)
            run_frame((i < 9) ? 1'($urandom) : 1'b0, 2'($urandom), 8'($urandom),
                      8'($urandom), 1'b0, -1);

        run_frame(1'b0, 2'b11, 8'($urandom), 8'hA5, 1'b0, 16);
        run_frame(1'b0, 2'b00, 8'($urandom), 8'h00, 1'b0, -1);
        idle_cycles(2);

        sel = 1'b1;
        idle_cycles(3);
        run_frame(1'b0, 2'b11, 8'($urandom), 8'h81, 1'b0, -1);
        for (int i = 0; i < 6; i++)
            run_frame((i < 5) ? 1'($urandom) : 1'b0, 2'($urandom), 8'($urandom),
                      8'($urandom), 1'b0, -1);
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
